tacky_dmem_responder: RTL and testbench

//  Memory-side responder for the dual-slot Tacky VLIW core's load/store path.

---
 rtl/tacky_dmem_responder_pkg.sv | 22 ++
 rtl/tacky_dmem_responder_if.sv | 28 ++
 rtl/tacky_rsp_fifo.sv | 51 +++++
 rtl/tacky_dmem_responder.sv | 133 +++++++++++++
 tb/tb_tacky_dmem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tacky_dmem_responder_pkg.sv
// Shared word/address widths, slot indices and default sizing for the Tacky data-memory responder.
package tacky_dmem_responder_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NSLOT  = 2;
    localparam int unsigned SLOT0  = 0;
    localparam int unsigned SLOT1  = 1;

    // Response queue entry: {err, data}
    localparam int unsigned RSP_W = WORD_W + 1;

    localparam int unsigned DEF_DEPTH   = 1024;
    localparam int unsigned DEF_LATENCY = 2;
    localparam int unsigned DEF_QDEPTH  = 4;

    // True when a word address falls inside the implemented array.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/tacky_dmem_responder_if.sv
// Dual-slot load/store request and read-response bundle between the core and the responder.
interface tacky_dmem_responder_if;
    import tacky_dmem_responder_pkg::*;

    logic [NSLOT-1:0]  req_valid;
    logic [NSLOT-1:0]  req_ready;
    logic [NSLOT-1:0]  req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [WORD_W-1:0] req_wdata0;
    logic [WORD_W-1:0] req_wdata1;
    logic [NSLOT-1:0]  rsp_valid;
    logic [NSLOT-1:0]  rsp_ready;
    logic [WORD_W-1:0] rsp_rdata0;
    logic [WORD_W-1:0] rsp_rdata1;
    logic [NSLOT-1:0]  rsp_err;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, rsp_err
    );

endinterface

// File: rtl/tacky_rsp_fifo.sv
// Per-slot read response queue; head is zero whenever the queue is empty.
module tacky_rsp_fifo #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned W      = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic                         not_empty,
    output logic [$clog2(QDEPTH+1)-1:0]  count
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [W-1:0]  mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (32'(p) == QDEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            if (push && !do_pop)      count <= count + CW'(1);
            else if (!push && do_pop) count <= count - CW'(1);
        end
    end

    // Entry storage; stale contents are masked by the empty check on head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tacky_dmem_responder.sv
// Memory-side responder for the dual-slot Tacky core: arbiter, credits, array, read delay line.
module tacky_dmem_responder
    import tacky_dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned QDEPTH  = DEF_QDEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    tacky_dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OUT_W = $clog2(QDEPTH + LATENCY + 1);

    logic                ready_en;
    logic [NSLOT-1:0]    credit_ok;
    logic [NSLOT-1:0]    req_ready_c;
    logic [NSLOT-1:0]    acc;
    logic [OUT_W-1:0]    out_cnt [NSLOT];
    logic [CNT_W-1:0]    q_cnt   [NSLOT];
    logic [RSP_W-1:0]    q_head  [NSLOT];
    logic [NSLOT-1:0]    q_ne;
    logic [NSLOT-1:0]    push;
    logic [NSLOT-1:0]    pop;

    logic                sel_slot;
    logic                sel_we;
    logic                sel_in_range;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WORD_W-1:0]   sel_wdata;
    logic [WORD_W-1:0]   sel_rdata;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [LATENCY-1:0]  pipe_vld;
    logic [LATENCY-1:0]  pipe_slot;
    logic [RSP_W-1:0]    pipe_rsp [LATENCY];

    // Hold off all requests until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Outstanding reads per slot: queued responses plus reads still in the delay line.
    always_comb begin
        for (int s = 0; s < NSLOT; s++) begin
            out_cnt[s] = OUT_W'(q_cnt[s]);
            for (int i = 0; i < LATENCY; i++) begin
                if (pipe_vld[i] && (pipe_slot[i] == 1'(s))) out_cnt[s] = out_cnt[s] + OUT_W'(1);
            end
        end
    end

    // Credit gating and fixed-priority arbitration; slot 1 yields to an accepted slot 0.
    always_comb begin
        for (int s = 0; s < NSLOT; s++) begin
            credit_ok[s] = ready_en && (bus.req_we[s] || (out_cnt[s] < OUT_W'(QDEPTH)));
        end
        req_ready_c[SLOT0] = credit_ok[SLOT0];
        req_ready_c[SLOT1] = credit_ok[SLOT1] && !(bus.req_valid[SLOT0] && credit_ok[SLOT0]);
    end

    assign bus.req_ready = req_ready_c;
    assign acc           = bus.req_valid & req_ready_c;

    // Select the single array access for this cycle and read the array combinationally.
    always_comb begin
        sel_slot     = acc[SLOT0] ? 1'b0 : 1'b1;
        sel_we       = acc[SLOT0] ? bus.req_we[SLOT0] : bus.req_we[SLOT1];
        sel_addr     = acc[SLOT0] ? bus.req_addr0     : bus.req_addr1;
        sel_wdata    = acc[SLOT0] ? bus.req_wdata0    : bus.req_wdata1;
        sel_in_range = addr_in_range(sel_addr, DEPTH);
        sel_rdata    = sel_in_range ? mem[sel_addr[IDX_W-1:0]] : '0;
    end

    // Array write in the accept cycle; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if ((|acc) && sel_we && sel_in_range) mem[sel_addr[IDX_W-1:0]] <= sel_wdata;
    end

    // Slot-tagged read delay line; stage 0 captures the array output at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld  <= '0;
            pipe_slot <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_rsp[i] <= '0;
        end else begin
            pipe_vld[0]  <= (|acc) && !sel_we;
            pipe_slot[0] <= sel_slot;
            pipe_rsp[0]  <= {!sel_in_range, sel_rdata};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_slot[i] <= pipe_slot[i-1];
                pipe_rsp[i]  <= pipe_rsp[i-1];
            end
        end
    end

    assign push[SLOT0] = pipe_vld[LATENCY-1] && !pipe_slot[LATENCY-1];
    assign push[SLOT1] = pipe_vld[LATENCY-1] &&  pipe_slot[LATENCY-1];
    assign pop         = q_ne & bus.rsp_ready;

    tacky_rsp_fifo #(.QDEPTH(QDEPTH), .W(RSP_W)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push[SLOT0]),
        .push_data (pipe_rsp[LATENCY-1]),
        .pop       (pop[SLOT0]),
        .head      (q_head[SLOT0]),
        .not_empty (q_ne[SLOT0]),
        .count     (q_cnt[SLOT0])
    );

    tacky_rsp_fifo #(.QDEPTH(QDEPTH), .W(RSP_W)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push[SLOT1]),
        .push_data (pipe_rsp[LATENCY-1]),
        .pop       (pop[SLOT1]),
        .head      (q_head[SLOT1]),
        .not_empty (q_ne[SLOT1]),
        .count     (q_cnt[SLOT1])
    );

    assign bus.rsp_valid  = q_ne;
    assign bus.rsp_err    = {q_head[SLOT1][WORD_W], q_head[SLOT0][WORD_W]};
    assign bus.rsp_rdata0 = q_head[SLOT0][WORD_W-1:0];
    assign bus.rsp_rdata1 = q_head[SLOT1][WORD_W-1:0];

endmodule

// File: tb/tb_tacky_dmem_responder.sv
// Self-checking bench for tacky_dmem_responder: vector table plus scoreboarded corner sequences.
module tb_tacky_dmem_responder;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [16:0] exp_q0 [$];
    logic [16:0] exp_q1 [$];
    logic [16:0] exp_e;

    typedef struct {
        logic        slot;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    tacky_dmem_responder_if bus ();

    tacky_dmem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response scoreboard: compare each popped head against the expected queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.rsp_valid[0] && bus.rsp_ready[0]) begin
                if (exp_q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp0_unexpected: got 0x%0h with nothing expected", {bus.rsp_err[0], bus.rsp_rdata0});
                end else begin
                    exp_e = exp_q0.pop_front();
                    chk("rsp0_data", {15'b0, bus.rsp_err[0], bus.rsp_rdata0}, {15'b0, exp_e});
                end
            end
            if (bus.rsp_valid[1] && bus.rsp_ready[1]) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp1_unexpected: got 0x%0h with nothing expected", {bus.rsp_err[1], bus.rsp_rdata1});
                end else begin
                    exp_e = exp_q1.pop_front();
                    chk("rsp1_data", {15'b0, bus.rsp_err[1], bus.rsp_rdata1}, {15'b0, exp_e});
                end
            end
        end
    end

    // Wait for an already-driven request to be accepted; record the expected read response.
    task automatic wait_accept(input int s, input logic do_push, input logic [16:0] exp,
                               input string name, output logic acc);
        acc = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            if (bus.req_ready[s]) acc = 1'b1;
            @(posedge clk);
            if (acc && do_push) begin
                if (s == 0) exp_q0.push_back(exp);
                else        exp_q1.push_back(exp);
            end
            #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL %s: got no accept expected accept within 40 cycles", name);
        end
    endtask

    task automatic drive(input int s, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus.req_we[s] = we;
        if (s == 0) begin bus.req_addr0 = addr; bus.req_wdata0 = wdata; end
        else        begin bus.req_addr1 = addr; bus.req_wdata1 = wdata; end
        bus.req_valid[s] = 1'b1;
    endtask

    task automatic issue(input int s, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [16:0] exp, input string name);
        logic acc;
        drive(s, we, addr, wdata);
        wait_accept(s, !we, exp, name, acc);
        bus.req_valid[s] = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 60 && (exp_q0.size() + exp_q1.size()) != 0; n++) begin
            @(posedge clk); #1;
        end
        chk(name, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        logic seen;

        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h03FF, 16'h2222, 16'h0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h2222, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0400, 16'hDEAD, 16'h0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 16'h0155, 16'hA5A5, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0155, 16'h0000, 16'hA5A5, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0155, 16'h5A5A, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0155, 16'h0000, 16'h5A5A, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0};

        reset          = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_we     = 2'b00;
        bus.req_addr0  = 16'h0;
        bus.req_addr1  = 16'h0;
        bus.req_wdata0 = 16'h0;
        bus.req_wdata1 = 16'h0;
        bus.rsp_ready  = 2'b00;
        #1 reset = 1'b0;

        // Reset: no readiness and quiet response outputs while held.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rdata",     {bus.rsp_rdata1, bus.rsp_rdata0}, 32'd0);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("rel_ready_before_edge", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_ready_after_edge", 32'(bus.req_ready), 32'd3);
        @(posedge clk); #1;

        // Vector table with both slots draining freely.
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            issue(int'(vecs[i].slot), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  {vecs[i].err, vecs[i].rdata}, $sformatf("vec%0d", i));
        end
        drain("vec_drain");

        // Write then read: response appears exactly two cycles after the read accept.
        issue(0, 1'b1, 16'h0010, 16'hBEEF, 17'h0, "t2_wr");
        issue(0, 1'b0, 16'h0010, 16'h0000, {1'b0, 16'hBEEF}, "t2_rd");
        @(negedge clk);
        chk("t2_lat_c0", 32'(bus.rsp_valid[0]), 32'd0);
        @(negedge clk);
        chk("t2_lat_c1", 32'(bus.rsp_valid[0]), 32'd0);
        @(negedge clk);
        chk("t2_lat_c2", 32'(bus.rsp_valid[0]), 32'd1);
        @(posedge clk); #1;
        drain("t2_drain");

        // Collision: slot 0 write wins, slot 1 read follows and sees the new data.
        drive(0, 1'b1, 16'h0020, 16'h1234);
        drive(1, 1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        chk("t3_ready_both", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_accept(1, 1'b1, {1'b0, 16'h1234}, "t3_slot1", acc);
        bus.req_valid[1] = 1'b0;
        drain("t3_drain");

        // Backpressure on slot 1: four outstanding reads cap the slot.
        for (int i = 0; i < 6; i++) issue(0, 1'b1, 16'(16'h0030 + i), 16'(16'hC000 + i), 17'h0, "t4_wr");
        bus.rsp_ready = 2'b01;
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 16'(16'h0030 + i), 16'h0, {1'b0, 16'(16'hC000 + i)}, "t4_rd");
        drive(1, 1'b0, 16'h0034, 16'h0000);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.req_ready[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("t4_cap_blocks", 32'(seen), 32'd0);
        chk("t4_rsp_pending", 32'(bus.rsp_valid[1]), 32'd1);
        bus.rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready[1] = 1'b0;
        wait_accept(1, 1'b1, {1'b0, 16'hC004}, "t4_refill", acc);
        bus.req_addr1 = 16'h0035;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.req_ready[1]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("t4_one_more_only", 32'(seen), 32'd0);
        bus.rsp_ready[1] = 1'b1;
        wait_accept(1, 1'b1, {1'b0, 16'hC005}, "t4_resume", acc);
        bus.req_valid[1] = 1'b0;
        drain("t4_drain");

        // Reset mid-flight: queued and in-flight reads vanish, array contents survive.
        for (int i = 0; i < 3; i++) issue(1, 1'b1, 16'(16'h0040 + i), 16'(16'h6000 + i), 17'h0, "t6_wr");
        bus.rsp_ready = 2'b00;
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 16'(16'h0040 + i), 16'h0, {1'b0, 16'(16'h6000 + i)}, "t6_rd");
        reset = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.rsp_ready = 2'b11;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("t6_no_spurious_rsp", 32'(seen), 32'd0);
        for (int i = 0; i < 3; i++) issue(0, 1'b0, 16'(16'h0040 + i), 16'h0, {1'b0, 16'(16'h6000 + i)}, "t6_readback");
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
